reloj_display_scan: RTL
=======================

// Module: reloj_display_scan
// PURPOSE
//  - Downstream consumer of the 24 h clock's digit bus.
//  - Walks the 3-bit digit address 0..5, samples the 4-bit BCD nibble returned on the bus,
//    and drives a 6-digit multiplexed common-anode 7-segment display.
//  - Digit order: 0=Us 1=Ds 2=Um 3=Dm 4=Uh 5=Dh. Display reads HH.MM.SS.
// PARAMETERS
//  - N_DIGITS  6      digits scanned; address wraps N_DIGITS-1 -> 0.
//  - SCAN_DIV  50000  clk cycles per digit slot. Must be >= SETTLE+3.
//  - SETTLE    2      cycles from driving direccion to sampling BUS; covers the upstream register.
// PORTS
//  - clk        in   1  system clock, rising edge.
//  - rst_n      in   1  asynchronous, active-low reset.
//  - BUS        in   4  BCD nibble from the clock for the current direccion.
//  - direccion  out  3  digit address driven to the clock.
//  - seg        out  7  {g,f,e,d,c,b,a}, active-low.
//  - dp         out  1  decimal point, active-low.
//  - an         out  6  digit anodes, active-low, one-hot-low when lit.
//  - slot_end   out  1  1-cycle pulse on the last cycle of each slot.
// BEHAVIOUR
//  - Reset values (async, active-low):
//    direccion=0, an=6'b111111, seg=7'b1111111, dp=1, slot_end=0.
//    Internally: idx=0, slot counter=0, state=ADDR.
//  - FSM, one slot per digit; slot counter cnt runs 0..SCAN_DIV-1:
//    - ADDR (cnt 0..SETTLE-1): direccion=idx, an all high (anti-ghost blanking).
//      At cnt=SETTLE-1 -> CAPT.
//    - CAPT (cnt=SETTLE): register BUS into nib. -> SHOW.
//    - SHOW (cnt SETTLE+1..SCAN_DIV-1): seg=decode(nib), an[idx]=0, other anodes 1.
//      dp=0 iff idx==2 or idx==4.
//      At cnt=SCAN_DIV-1: slot_end=1, idx advances (N_DIGITS-1 wraps to 0), cnt=0 -> ADDR.
//  - Latency: BUS sampled SETTLE cycles after direccion changes. Segments valid one cycle after capture.
//  - Outputs are registered, and an/seg/dp change on the same edge.
//    In ADDR and CAPT, seg=7'b1111111 and dp=1.
//  - Decode (active-low):
//    0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//    5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//    Any nibble 10..15 shows a dash: 0111111.
//  - BUS changing mid-slot (clock tick) has no effect until the digit's next slot. No tearing within a slot.
//  - rst_n asserted mid-slot: immediate return to reset values. Scan restarts at idx 0, cnt 0.
// CONFIGURATION
//  - Macro BLANK_LEADING_ZERO_EN.
//  - Defined: in SHOW with idx==5 and nib==0, seg=7'b1111111 and an[5]=1.
//    Dh is dark for hours 00..09. Slot timing is unchanged.
//  - Undefined: Dh=0 is shown as '0' like every other digit.
// STRUCTURE
//  - Package reloj_pkg holds:
//    - digit index constants (DIG_US..DIG_DH);
//    - SEG_BLANK, SEG_DASH and the SEG_0..SEG_9 constants;
//    - the FSM state enum {ADDR, CAPT, SHOW}.
//  - One sub-module, seg7_decode: combinational nibble -> seg lookup, shared with other display blocks.
//  - The scanner FSM, counters and output registers stay in this module.
// TESTING (bench params: SCAN_DIV=8, SETTLE=2; BUS modelled as a registered lookup of direccion)
//  - Reset: hold rst_n=0 for 3 clk.
//    -> direccion=0, an=111111, seg=1111111, dp=1.
//    After release, an[0] first goes low on cycle 3.
//  - Full scan, time 23:59:58 (Us=8 Ds=5 Um=9 Dm=5 Uh=3 Dh=2):
//    -> direccion steps 0..5 every 8 cycles.
//    -> seg sequence 0000000, 0010010, 0010000, 0010010, 0110000, 0100100.
//    -> dp low only in slots 2 and 4.
//    -> slot_end pulses every 8 cycles.
//  - BUS driving 4'hC in slot 1 -> seg=0111111 in that slot; the other digits are unaffected.
//  - BUS changes 3->4 at cnt=5 of slot 0 -> seg holds 0110000 until slot_end.
//    The next slot-0 visit shows 0011001.
//  - Wrap and reset: the address after 5 is 0.
//    rst_n pulsed at cnt=4 of slot 3 -> outputs return to reset values at once; scan resumes at idx 0.
//  - BLANK_LEADING_ZERO_EN defined, Dh=0 -> slot 5 has an=111111 and seg=1111111.
//    Undefined -> an[5]=0 and seg=1000000.

Source files
------------

// File: rtl/reloj_pkg.sv
// rtl/reloj_pkg.sv - shared constants and FSM state type for the clock display scanner
package reloj_pkg;

   localparam logic [2:0] DIG_US = 3'd0;
   localparam logic [2:0] DIG_DS = 3'd1;
   localparam logic [2:0] DIG_UM = 3'd2;
   localparam logic [2:0] DIG_DM = 3'd3;
   localparam logic [2:0] DIG_UH = 3'd4;
   localparam logic [2:0] DIG_DH = 3'd5;

   // segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   typedef enum logic [1:0] {
      ADDR = 2'd0,
      CAPT = 2'd1,
      SHOW = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD nibble to active-low 7-segment lookup
module seg7_decode
   import reloj_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/reloj_display_scan.sv
// rtl/reloj_display_scan.sv - 6-digit multiplexed 7-segment scanner reading the clock digit bus
// Optional: BLANK_LEADING_ZERO_EN darkens the tens-of-hours digit when it is zero.
module reloj_display_scan
   import reloj_pkg::*;
#(
   parameter int N_DIGITS = 6,
   parameter int SCAN_DIV = 50000,
   parameter int SETTLE   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] BUS,
   output logic [2:0] direccion,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       slot_end
);

   localparam int CW = $clog2(SCAN_DIV);

   scan_state_t   state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [2:0]    idx, nxt_idx;
   logic [3:0]    nib, nxt_nib;
   logic [6:0]    dec_seg;
   logic          blank_lz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ADDR;
         cnt   <= '0;
         idx   <= '0;
         nib   <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         idx   <= nxt_idx;
         nib   <= nxt_nib;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      nxt_idx   = idx;
      nxt_nib   = nib;
      case (state)
         ADDR: begin
            if (cnt == CW'(SETTLE - 1))
               nxt_state = CAPT;
         end
         CAPT: begin
            nxt_nib   = BUS;
            nxt_state = SHOW;
         end
         SHOW: begin
            if (cnt == CW'(SCAN_DIV - 1)) begin
               nxt_state = ADDR;
               nxt_cnt   = '0;
               nxt_idx   = (idx == 3'(N_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end
         end
         default: begin
            nxt_state = ADDR;
            nxt_cnt   = '0;
         end
      endcase
   end

   // decode the nibble the next cycle will show, so seg/an/dp land on one edge
   seg7_decode u_dec (
      .nib (nxt_nib),
      .seg (dec_seg)
   );

`ifdef BLANK_LEADING_ZERO_EN
   assign blank_lz = (nxt_idx == DIG_DH) && (nxt_nib == 4'd0);
`else
   assign blank_lz = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         direccion <= '0;
         an        <= 6'b111111;
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
         slot_end  <= 1'b0;
      end else begin
         direccion <= nxt_idx;
         slot_end  <= (nxt_state == SHOW) && (nxt_cnt == CW'(SCAN_DIV - 1));
         if (nxt_state == SHOW) begin
            an  <= blank_lz ? 6'b111111 : ~(6'b000001 << nxt_idx);
            seg <= blank_lz ? SEG_BLANK : dec_seg;
            dp  <= !((nxt_idx == DIG_UM) || (nxt_idx == DIG_UH));
         end else begin
            an  <= 6'b111111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end
      end
   end

endmodule
